// File: rtl/cve2_rvfi_trace_buffer.sv
// RVFI retirement trace buffer: PC-window filter feeding a FWFT record FIFO.
// Full buffer either drops the newest record or overwrites the oldest.
module cve2_rvfi_trace_buffer #(
    parameter int unsigned Depth        = 16,
    parameter int unsigned OrderWidth   = 16,
    parameter int unsigned DropCntWidth = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       cfg_en_i,
    input  logic                       cfg_wrap_i,
    input  logic                       cfg_filter_en_i,
    input  logic [31:0]                cfg_pc_lo_i,
    input  logic [31:0]                cfg_pc_hi_i,
    input  logic                       clear_i,
    input  logic                       rvfi_valid,
    input  logic [63:0]                rvfi_order,
    input  logic [31:0]                rvfi_pc_rdata,
    input  logic [31:0]                rvfi_insn,
    input  logic [4:0]                 rvfi_rd_addr,
    input  logic [31:0]                rvfi_rd_wdata,
    input  logic                       rvfi_trap,
    input  logic                       rvfi_intr,
    output logic                       rd_valid_o,
    input  logic                       rd_ready_i,
    output logic [OrderWidth-1:0]      rd_order_o,
    output logic [31:0]                rd_pc_o,
    output logic [31:0]                rd_insn_o,
    output logic [4:0]                 rd_rd_addr_o,
    output logic [31:0]                rd_rd_wdata_o,
    output logic                       rd_trap_o,
    output logic                       rd_intr_o,
    output logic [$clog2(Depth):0]     level_o,
    output logic                       overflow_o,
    output logic [DropCntWidth-1:0]    dropped_cnt_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned LvlW = PtrW + 1;

    typedef struct packed {
        logic [OrderWidth-1:0] order;
        logic [31:0]           pc;
        logic [31:0]           insn;
        logic [4:0]            rd_addr;
        logic [31:0]           rd_wdata;
        logic                  trap;
        logic                  intr;
    } rec_t;

    rec_t            mem [Depth];
    rec_t            wr_rec;
    rec_t            rd_rec;
    logic [PtrW-1:0] wptr;
    logic [PtrW-1:0] rptr;
    logic [LvlW-1:0] level;

    logic in_window;
    logic cap;
    logic full;
    logic pop;
    logic ovf_evt;
    logic wr_en;
    logic rd_adv;

    if (OrderWidth < 64) begin : g_order_unused
        logic unused_order;
        assign unused_order = ^rvfi_order[63:OrderWidth];
    end

    assign in_window = (rvfi_pc_rdata >= cfg_pc_lo_i) &&
                       (rvfi_pc_rdata <= cfg_pc_hi_i);
    assign cap = rvfi_valid & cfg_en_i &
                 (~cfg_filter_en_i | rvfi_trap | in_window);

    assign full     = (level == LvlW'(Depth));
    assign pop      = rd_valid_o & rd_ready_i;
    // A capture into a full buffer with no pop to make room is lost either way.
    assign ovf_evt  = cap & full & ~pop;
    assign wr_en    = ~clear_i & cap & (~full | pop | cfg_wrap_i);
    // Wrap mode evicts the oldest record by moving the read side along.
    assign rd_adv   = ~clear_i & (pop | (ovf_evt & cfg_wrap_i));

    assign wr_rec.order    = rvfi_order[OrderWidth-1:0];
    assign wr_rec.pc       = rvfi_pc_rdata;
    assign wr_rec.insn     = rvfi_insn;
    assign wr_rec.rd_addr  = rvfi_rd_addr;
    assign wr_rec.rd_wdata = rvfi_rd_wdata;
    assign wr_rec.trap     = rvfi_trap;
    assign wr_rec.intr     = rvfi_intr;

    // Record storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wptr] <= wr_rec;
        end
    end

    // Pointers, fill level and overflow status.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr          <= '0;
            rptr          <= '0;
            level         <= '0;
            overflow_o    <= 1'b0;
            dropped_cnt_o <= '0;
        end else if (clear_i) begin
            wptr          <= '0;
            rptr          <= '0;
            level         <= '0;
            overflow_o    <= 1'b0;
            dropped_cnt_o <= '0;
        end else begin
            if (wr_en) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_adv) begin
                rptr <= rptr + 1'b1;
            end
            if (wr_en && !rd_adv) begin
                level <= level + 1'b1;
            end else if (!wr_en && rd_adv) begin
                level <= level - 1'b1;
            end
            if (ovf_evt) begin
                overflow_o <= 1'b1;
                if (dropped_cnt_o != '1) begin
                    dropped_cnt_o <= dropped_cnt_o + 1'b1;
                end
            end
        end
    end

    assign rd_rec        = mem[rptr];
    assign rd_valid_o    = (level != '0);
    assign level_o       = level;
    assign rd_order_o    = rd_rec.order;
    assign rd_pc_o       = rd_rec.pc;
    assign rd_insn_o     = rd_rec.insn;
    assign rd_rd_addr_o  = rd_rec.rd_addr;
    assign rd_rd_wdata_o = rd_rec.rd_wdata;
    assign rd_trap_o     = rd_rec.trap;
    assign rd_intr_o     = rd_rec.intr;

endmodule

// File: tb/tb_cve2_rvfi_trace_buffer.sv
// Randomised and directed bench for the RVFI trace buffer.
// Reference model: a record queue with drop/evict rules.
module tb_cve2_rvfi_trace_buffer;

    localparam int Depth = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_en = 1'b0;
    logic        cfg_wrap = 1'b0;
    logic        cfg_filt = 1'b0;
    logic [31:0] cfg_lo = '0;
    logic [31:0] cfg_hi = '0;
    logic        clear = 1'b0;
    logic        valid = 1'b0;
    logic [63:0] order = '0;
    logic [31:0] pc = '0;
    logic [31:0] insn = '0;
    logic [4:0]  rd_addr = '0;
    logic [31:0] rd_wdata = '0;
    logic        trap = 1'b0;
    logic        intr = 1'b0;
    logic        rd_ready = 1'b0;

    logic        o_valid, s_valid;
    logic [15:0] o_order, s_order;
    logic [31:0] o_pc, s_pc, o_insn, s_insn, o_wd, s_wd;
    logic [4:0]  o_rd, s_rd;
    logic        o_trap, s_trap, o_intr, s_intr;
    logic [4:0]  o_level, s_level;
    logic        o_ovf, s_ovf;
    logic [7:0]  o_cnt;
    logic [1:0]  s_cnt;

    always #5 clk = ~clk;

    cve2_rvfi_trace_buffer #(.Depth(16), .OrderWidth(16), .DropCntWidth(8)) dut (
        .clk_i(clk), .rst_ni(rst_n), .cfg_en_i(cfg_en), .cfg_wrap_i(cfg_wrap),
        .cfg_filter_en_i(cfg_filt), .cfg_pc_lo_i(cfg_lo), .cfg_pc_hi_i(cfg_hi),
        .clear_i(clear), .rvfi_valid(valid), .rvfi_order(order),
        .rvfi_pc_rdata(pc), .rvfi_insn(insn), .rvfi_rd_addr(rd_addr),
        .rvfi_rd_wdata(rd_wdata), .rvfi_trap(trap), .rvfi_intr(intr),
        .rd_valid_o(o_valid), .rd_ready_i(rd_ready), .rd_order_o(o_order),
        .rd_pc_o(o_pc), .rd_insn_o(o_insn), .rd_rd_addr_o(o_rd),
        .rd_rd_wdata_o(o_wd), .rd_trap_o(o_trap), .rd_intr_o(o_intr),
        .level_o(o_level), .overflow_o(o_ovf), .dropped_cnt_o(o_cnt)
    );

    cve2_rvfi_trace_buffer #(.Depth(16), .OrderWidth(16), .DropCntWidth(2)) dut_s (
        .clk_i(clk), .rst_ni(rst_n), .cfg_en_i(cfg_en), .cfg_wrap_i(cfg_wrap),
        .cfg_filter_en_i(cfg_filt), .cfg_pc_lo_i(cfg_lo), .cfg_pc_hi_i(cfg_hi),
        .clear_i(clear), .rvfi_valid(valid), .rvfi_order(order),
        .rvfi_pc_rdata(pc), .rvfi_insn(insn), .rvfi_rd_addr(rd_addr),
        .rvfi_rd_wdata(rd_wdata), .rvfi_trap(trap), .rvfi_intr(intr),
        .rd_valid_o(s_valid), .rd_ready_i(rd_ready), .rd_order_o(s_order),
        .rd_pc_o(s_pc), .rd_insn_o(s_insn), .rd_rd_addr_o(s_rd),
        .rd_rd_wdata_o(s_wd), .rd_trap_o(s_trap), .rd_intr_o(s_intr),
        .level_o(s_level), .overflow_o(s_ovf), .dropped_cnt_o(s_cnt)
    );

    typedef struct {
        logic [15:0] order;
        logic [31:0] pc;
        logic [31:0] insn;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic        trap;
        logic        intr;
    } rec_t;

    rec_t q[$];
    bit   m_ovf;
    int   m_cnt;
    int   n_chk;
    int   n_pass;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // One clock: check outputs mid-cycle, then advance the model on the edge.
    task automatic cycle();
        bit   cap;
        bit   pop;
        rec_t r;
        @(negedge clk);
        chk("level", o_level, q.size());
        chk("valid", o_valid, q.size() != 0);
        chk("ovf", o_ovf, m_ovf);
        chk("drop", o_cnt, sat(m_cnt, 255));
        chk("drop_small", s_cnt, sat(m_cnt, 3));
        if (q.size() != 0) begin
            chk("pc", o_pc, q[0].pc);
            chk("order", o_order, q[0].order);
            chk("insn", o_insn, q[0].insn);
            chk("rd", o_rd, q[0].rd);
            chk("wdata", o_wd, q[0].wd);
            chk("trap", o_trap, q[0].trap);
            chk("intr", o_intr, q[0].intr);
        end
        cap = valid && cfg_en &&
              (!cfg_filt || trap || (pc >= cfg_lo && pc <= cfg_hi));
        pop = (q.size() != 0) && rd_ready;
        r.order = order[15:0];
        r.pc = pc;
        r.insn = insn;
        r.rd = rd_addr;
        r.wd = rd_wdata;
        r.trap = trap;
        r.intr = intr;
        @(posedge clk);
        #1;
        if (clear) begin
            q.delete();
            m_ovf = 0;
            m_cnt = 0;
        end else begin
            if (pop) void'(q.pop_front());
            if (cap) begin
                if (q.size() < Depth) begin
                    q.push_back(r);
                end else begin
                    m_ovf = 1;
                    m_cnt++;
                    if (cfg_wrap) begin
                        void'(q.pop_front());
                        q.push_back(r);
                    end
                end
            end
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] p, input logic t);
        valid = v;
        pc = p;
        trap = t;
        order = {$urandom, $urandom};
        insn = $urandom;
        rd_addr = 5'($urandom);
        rd_wdata = $urandom;
        intr = 1'($urandom);
    endtask

    task automatic do_clear();
        drive(1'b0, 32'h0, 1'b0);
        clear = 1'b1;
        cycle();
        clear = 1'b0;
    endtask

    initial begin
        logic [31:0] plist [5];
        n_chk = 0;
        n_pass = 0;
        m_ovf = 0;
        m_cnt = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_level", o_level, 0);
        chk("reset_valid", o_valid, 0);
        chk("reset_ovf", o_ovf, 0);
        chk("reset_drop", o_cnt, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cfg_en = 1'b1;

        // In-order capture and drain.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h100 + 32'(4 * i), 1'b0);
            cycle();
        end
        drive(1'b0, 32'h0, 1'b0);
        cycle();
        chk("t1_level", o_level, 5);
        chk("t1_pc", o_pc, 32'h100);
        rd_ready = 1'b1;
        repeat (6) cycle();
        chk("t1_drained", o_valid, 0);
        rd_ready = 1'b0;

        // PC window filter, trap bypasses it.
        cfg_filt = 1'b1;
        cfg_lo = 32'h200;
        cfg_hi = 32'h2FF;
        plist[0] = 32'h1FC;
        plist[1] = 32'h200;
        plist[2] = 32'h2FF;
        plist[3] = 32'h300;
        plist[4] = 32'h400;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, plist[i], i == 4);
            cycle();
        end
        drive(1'b0, 32'h0, 1'b0);
        cycle();
        chk("t2_level", o_level, 3);
        chk("t2_pc", o_pc, 32'h200);
        cfg_filt = 1'b0;

        // Stop mode overflow and small-counter saturation.
        do_clear();
        for (int i = 0; i < 18; i++) begin
            drive(1'b1, 32'h1000 + 32'(4 * i), 1'b0);
            cycle();
        end
        chk("t3_level", o_level, 16);
        chk("t3_pc", o_pc, 32'h1000);
        chk("t3_drop", o_cnt, 2);
        chk("t3_ovf", o_ovf, 1);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'h1100 + 32'(4 * i), 1'b0);
            cycle();
        end
        chk("t3_drop8", o_cnt, 8);
        chk("t3_sat", s_cnt, 3);

        // Wrap mode overwrites oldest.
        do_clear();
        cfg_wrap = 1'b1;
        for (int i = 0; i < 18; i++) begin
            drive(1'b1, 32'h2000 + 32'(4 * i), 1'b0);
            cycle();
        end
        chk("t4_level", o_level, 16);
        chk("t4_pc", o_pc, 32'h2008);
        chk("t4_drop", o_cnt, 2);
        cfg_wrap = 1'b0;

        // Full with simultaneous capture and pop.
        do_clear();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 32'h3000 + 32'(4 * i), 1'b0);
            cycle();
        end
        rd_ready = 1'b1;
        drive(1'b1, 32'h3100, 1'b0);
        cycle();
        rd_ready = 1'b0;
        chk("t5_level", o_level, 16);
        chk("t5_ovf", o_ovf, 0);
        chk("t5_pc", o_pc, 32'h3004);
        drive(1'b1, 32'h3200, 1'b0);
        cycle();
        drive(1'b1, 32'h3204, 1'b0);
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        chk("t5_clr_level", o_level, 0);
        chk("t5_clr_drop", o_cnt, 0);
        chk("t5_clr_valid", o_valid, 0);

        // Asynchronous reset mid-stream.
        cfg_wrap = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 32'h4000 + 32'(4 * i), 1'b0);
            cycle();
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_level", o_level, 0);
        chk("arst_valid", o_valid, 0);
        chk("arst_ovf", o_ovf, 0);
        chk("arst_drop", o_cnt, 0);
        chk("arst_drop_small", s_cnt, 0);
        q.delete();
        m_ovf = 0;
        m_cnt = 0;
        drive(1'b0, 32'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Randomised traffic.
        for (int i = 0; i < 2500; i++) begin
            if (i % 100 == 0) cfg_wrap = 1'($urandom);
            if (i % 150 == 0) cfg_filt = 1'($urandom);
            if (i % 37 == 0) begin
                cfg_lo = $urandom_range(32'h180, 32'h380);
                cfg_hi = $urandom_range(32'h180, 32'h380);
            end
            cfg_en = ($urandom % 16) != 0;
            clear = ($urandom % 80) == 0;
            rd_ready = ($urandom % 4) < ((i / 250) % 4);
            drive(($urandom % 4) != 0,
                  $urandom_range(32'h170, 32'h390) & 32'hFFFF_FFFC,
                  ($urandom % 8) == 0);
            cycle();
        end
        clear = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
